uart_byte_rx: RTL



---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/rx_sync_2ff.sv | 32 +++
 rtl/uart_byte_rx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART byte receiver: FSM encoding, data width, bit-period helper.
// No logic of its own; latency and backpressure are properties of the users of this package.
package uart_rx_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Integer division on purpose: the residual baud error is absorbed by mid-bit sampling.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input, reset to RST_VAL (idle-high lines, buttons).
// Latency 2 clocks; no backpressure, the input is simply sampled every cycle.
module rx_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART receiver, 8N1 LSB first (8E1 when UART_RX_PARITY_EN is defined), holding the last good byte.
// Latency ~9.5 bit times + 3 clocks from start edge; no backpressure, each good byte overwrites DATA_OUT.
module uart_byte_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 9600
) (
  input  logic              CLK_12MHz,
  input  logic              RST,
  input  logic              RX_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_s;
  logic              half_done;
  logic              bit_done;
  logic              frame_bad;
  logic              busy;

  rx_sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(CLK_12MHz),
    .rst(RST),
    .d  (RX_IN),
    .q  (rx_s)
  );

  assign half_done = (clk_cnt_q == HALF_LAST);
  assign bit_done  = (clk_cnt_q == BIT_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign frame_bad = par_err_q;
`else
  assign frame_bad = 1'b0;
`endif

  always_ff @(posedge CLK_12MHz) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: if (half_done) state_d = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (bit_done && bit_idx_q == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (bit_done) state_d = ST_STOP;
`else
      ST_DATA:   if (bit_done && bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
      // A low stop bit may be the start of a break; wait for the line to recover.
      ST_STOP:      if (bit_done) state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (rx_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
`endif
    case (state_q)
      ST_START: begin
        if (half_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          par_err_d = (^shift_q) ^ rx_s;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (rx_s && !frame_bad) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
      end
      default: clk_cnt_d = '0;
    endcase
  end

  always_ff @(posedge CLK_12MHz) begin
    if (RST) begin
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
`endif
    end
  end

  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = busy;

endmodule
